// File: rtl/out_fm_pkg.sv
// Shared types and constants for the out_fm write-back mover.
// Optional feature macro used by this block: OUT_FM_RELU_EN.
package out_fm_pkg;

  // Default geometry; the top exposes these as overridable parameters.
  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_M  = 32;
  localparam int unsigned DEF_R  = 64;
  localparam int unsigned DEF_C  = 32;
  localparam int unsigned DEF_TM = 8;
  localparam int unsigned DEF_TR = 16;
  localparam int unsigned DEF_TC = 8;

  localparam int unsigned TILE_WORDS = DEF_TM * DEF_TR * DEF_TC;
  localparam int unsigned MAP_STRIDE = DEF_R * DEF_C;
  localparam int unsigned ROW_STRIDE = DEF_C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/nest3_counter.sv
// Three-level nested counter (n0 innermost); done_c flags the final enabled step.
module nest3_counter #(
  parameter int unsigned CW     = 32,
  parameter int unsigned N0_MAX = 8,
  parameter int unsigned N1_MAX = 16,
  parameter int unsigned N2_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] n0,
  output logic [CW-1:0] n1,
  output logic [CW-1:0] n2,
  output logic          done_c
);

  localparam logic [CW-1:0] N0_LAST = CW'(N0_MAX - 1);
  localparam logic [CW-1:0] N1_LAST = CW'(N1_MAX - 1);
  localparam logic [CW-1:0] N2_LAST = CW'(N2_MAX - 1);

  logic n0_last, n1_last, n2_last;

  assign n0_last = (n0 == N0_LAST);
  assign n1_last = (n1 == N1_LAST);
  assign n2_last = (n2 == N2_LAST);
  assign done_c  = en && n0_last && n1_last && n2_last;

  // Step the nest on each enable; all levels wrap to 0 after the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n0 <= '0;
      n1 <= '0;
      n2 <= '0;
    end else if (en) begin
      if (n0_last) begin
        n0 <= '0;
        if (n1_last) begin
          n1 <= '0;
          n2 <= n2_last ? '0 : n2 + CW'(1);
        end else begin
          n1 <= n1 + CW'(1);
        end
      end else begin
        n0 <= n0 + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_to_out_fm_ram.sv
// Moves one Tm x Tr x Tc output tile from the output FIFO into out_fm RAM
// (row-major [M][R][C]); padding words outside the map are popped but not written.
// Define OUT_FM_RELU_EN to clamp negative words to zero on the way to RAM.
module fifo_to_out_fm_ram
  import out_fm_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned M  = DEF_M,
  parameter int unsigned R  = DEF_R,
  parameter int unsigned C  = DEF_C,
  parameter int unsigned Tm = DEF_TM,
  parameter int unsigned Tr = DEF_TR,
  parameter int unsigned Tc = DEF_TC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          fifo_pop,
  input  logic          fifo_empty,
  input  logic [DW-1:0] data_from_fifo,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] data_to_ram,
  input  logic [AW-1:0] tile_base_m,
  input  logic [AW-1:0] tile_base_row,
  input  logic [AW-1:0] tile_base_col
);

  localparam logic [AW-1:0] MAP_STR = AW'(R * C);
  localparam logic [AW-1:0] ROW_STR = AW'(C);
  localparam logic [AW-1:0] M_LIM   = AW'(M);
  localparam logic [AW-1:0] R_LIM   = AW'(R);
  localparam logic [AW-1:0] C_LIM   = AW'(C);

  state_e        state_q, state_d;
  logic          done_d;
  logic          last_pop_c;
  logic          pop_d1;
  logic [AW-1:0] bm_q, br_q, bc_q;
  logic [AW-1:0] tm, tr, tc;
  logic [AW-1:0] m_idx, r_idx, c_idx;
  logic [AW-1:0] addr_c;
  logic          legal_c;
  logic [DW-1:0] word_c;

  nest3_counter #(
    .CW    (AW),
    .N0_MAX(Tc),
    .N1_MAX(Tr),
    .N2_MAX(Tm)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (fifo_pop),
    .n0    (tc),
    .n1    (tr),
    .n2    (tm),
    .done_c(last_pop_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pop_c) state_d = DRAIN;
      DRAIN:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop whenever running with data available; done tracks FIN.
  always_comb begin
    fifo_pop = 1'b0;
    done_d   = 1'b0;
    fifo_pop = (state_q == RUN) && !fifo_empty;
    done_d   = (state_d == FIN);
  end

  // Register done so it is a clean one-cycle pulse during FIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done <= 1'b0;
    else      done <= done_d;
  end

  // Capture the tile origin when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bm_q <= '0;
      br_q <= '0;
      bc_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      bm_q <= tile_base_m;
      br_q <= tile_base_row;
      bc_q <= tile_base_col;
    end
  end

  // Absolute coordinates, linear address (mod 2^AW) and in-map check.
  assign m_idx   = bm_q + tm;
  assign r_idx   = br_q + tr;
  assign c_idx   = bc_q + tc;
  assign addr_c  = m_idx * MAP_STR + r_idx * ROW_STR + c_idx;
  assign legal_c = (m_idx < M_LIM) && (r_idx < R_LIM) && (c_idx < C_LIM);

  // Write stage lines up with the FIFO's one-cycle read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wena <= 1'b0;
      ram_addr <= '0;
      pop_d1   <= 1'b0;
    end else begin
      ram_wena <= fifo_pop && legal_c;
      pop_d1   <= fifo_pop;
      if (fifo_pop) ram_addr <= addr_c;
    end
  end

`ifdef OUT_FM_RELU_EN
  assign word_c = data_from_fifo[DW-1] ? '0 : data_from_fifo;
`else
  assign word_c = data_from_fifo;
`endif

  // Read data is only meaningful the cycle after a pop; hold zero otherwise.
  assign data_to_ram = pop_d1 ? word_c : '0;

endmodule

// File: tb/tb_fifo_to_out_fm_ram.sv
// Randomised bench for fifo_to_out_fm_ram with a tile-level reference model.
// Honours OUT_FM_RELU_EN the same way the design does.
module tb_fifo_to_out_fm_ram;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned M  = 32;
  localparam int unsigned R  = 64;
  localparam int unsigned C  = 32;
  localparam int unsigned TM = 8;
  localparam int unsigned TR = 16;
  localparam int unsigned TC = 8;
  localparam int          N  = TM * TR * TC;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic          fifo_pop;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] data_from_fifo = '0;
  logic          ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] data_to_ram;
  logic [AW-1:0] tile_base_m = '0;
  logic [AW-1:0] tile_base_row = '0;
  logic [AW-1:0] tile_base_col = '0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pops = 0;
  int          writes = 0;
  int          dones = 0;
  int          done_cyc = 0;
  bit          pop_seen = 1'b0;
  logic [31:0] wa [9];
  logic [31:0] wd [2];
  logic [31:0] last_addr = '0;
  logic [31:0] words [N];
  wr_t         exp_q [$];
  wr_t         mon_e;

  always #5 clk = ~clk;

  fifo_to_out_fm_ram dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .done          (done),
    .fifo_pop      (fifo_pop),
    .fifo_empty    (fifo_empty),
    .data_from_fifo(data_from_fifo),
    .ram_wena      (ram_wena),
    .ram_addr      (ram_addr),
    .data_to_ram   (data_to_ram),
    .tile_base_m   (tile_base_m),
    .tile_base_row (tile_base_row),
    .tile_base_col (tile_base_col)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef OUT_FM_RELU_EN
    return w[31] ? 32'd0 : w;
`else
    return w;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count pops/writes/done and score every RAM write in order.
  always @(negedge clk) begin
    pop_seen = fifo_pop;
    if (fifo_pop) pops++;
    if (ram_wena) begin
      if (writes < 9) wa[writes] = ram_addr;
      if (writes < 2) wd[writes] = data_to_ram;
      writes++;
      last_addr = ram_addr;
      if (exp_q.size() == 0) begin
        check("extra_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", ram_addr, mon_e.addr);
        check("wr_data", data_to_ram, mon_e.data);
      end
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
  end

  // Build the FIFO stream and the list of writes the tile should produce.
  task automatic build_tile(input logic [31:0] bm, input logic [31:0] br, input logic [31:0] bc,
                            output int n_legal);
    n_legal = 0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      logic [31:0] m, r, c;
      words[k] = $urandom;
      m = bm + 32'(k / (TR * TC));
      r = br + 32'((k / TC) % TR);
      c = bc + 32'(k % TC);
      if (m < M && r < R && c < C) begin
        exp_q.push_back('{addr: m * R * C + r * C + c, data: 32'd0});
        n_legal++;
      end
    end
  endtask

  // mode: 0 FIFO never empty, 1 empty toggles every 3 cycles, 2 random empty.
  task automatic run_tile(input logic [31:0] bm, input logic [31:0] br, input logic [31:0] bc,
                          input int mode, input bit repulse, input int abort_at,
                          input bit relu_words);
    int n_legal;
    int start_cyc;
    int k;
    int idx;
    build_tile(bm, br, bc, n_legal);
    if (relu_words) begin
      words[0] = 32'hFFFF_FFFF;
      words[1] = 32'h0000_0005;
    end
    idx = 0;
    for (int k2 = 0; k2 < N; k2++) begin
      logic [31:0] m, r, c;
      m = bm + 32'(k2 / (TR * TC));
      r = br + 32'((k2 / TC) % TR);
      c = bc + 32'(k2 % TC);
      if (m < M && r < R && c < C) begin
        exp_q[idx].data = model_word(words[k2]);
        idx++;
      end
    end
    @(posedge clk); #1;
    pops = 0; writes = 0; dones = 0; done_cyc = 0;
    tile_base_m = bm; tile_base_row = br; tile_base_col = bc;
    fifo_empty = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    tile_base_m = $urandom; tile_base_row = $urandom; tile_base_col = $urandom;
    k = 0;
    while (dones == 0 && k < 6000) begin
      if (pop_seen) data_from_fifo = words[pops - 1];
      case (mode)
        1:       fifo_empty = ((k / 3) % 2) == 1;
        2:       fifo_empty = ($urandom_range(0, 3) == 0);
        default: fifo_empty = 1'b0;
      endcase
      start = repulse && (k == 20);
      if (abort_at > 0 && pops >= abort_at) begin
        rst = 1'b0;
        #1;
        check("rst_pop", 32'(fifo_pop), 32'd0);
        check("rst_wena", 32'(ram_wena), 32'd0);
        check("rst_addr", ram_addr, 32'd0);
        check("rst_data", data_to_ram, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b0;
        fifo_empty = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_idle_pop", 32'(fifo_pop), 32'd0);
        exp_q.delete();
        return;
      end
      @(negedge clk);
      if (repulse && done) start = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (dones == 0) check("timeout_done", 32'd0, 32'd1);
    fifo_empty = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pops", 32'(pops), 32'(N));
    check("writes", 32'(writes), 32'(n_legal));
    check("sb_left", 32'(exp_q.size()), 32'd0);
    check("dones", 32'(dones), 32'd1);
    if (mode == 0) check("latency", 32'(done_cyc - start_cyc), 32'(N + 2));
  endtask

  initial begin
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_pop", 32'(fifo_pop), 32'd0);
    check("reset_wena", 32'(ram_wena), 32'd0);
    check("reset_addr", ram_addr, 32'd0);
    check("reset_data", data_to_ram, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Interior tile at the origin with a full FIFO.
    run_tile(32'd0, 32'd0, 32'd0, 0, 1'b0, 0, 1'b1);
    check("addr_w1", wa[0], 32'd0);
    check("addr_w8", wa[7], 32'd7);
    check("addr_w9", wa[8], 32'd32);
`ifdef OUT_FM_RELU_EN
    check("relu_neg", wd[0], 32'h0000_0000);
`else
    check("relu_neg", wd[0], 32'hFFFF_FFFF);
`endif
    check("relu_pos", wd[1], 32'h0000_0005);

    // Edge tile: only 4x8x4 words land inside the map.
    run_tile(32'd28, 32'd56, 32'd28, 0, 1'b0, 0, 1'b0);
    check("edge_writes", 32'(writes), 32'd128);
    check("edge_last_addr", last_addr, 32'd65535);

    // FIFO empty every 3 cycles, random origin.
    run_tile(32'($urandom_range(0, 31)), 32'($urandom_range(0, 63)), 32'($urandom_range(0, 31)),
             1, 1'b0, 0, 1'b0);

    // Random empties, start re-pulsed in RUN and FIN.
    run_tile(32'($urandom_range(0, 31)), 32'($urandom_range(0, 63)), 32'($urandom_range(0, 31)),
             2, 1'b1, 0, 1'b0);

    // Reset mid-tile, then the tile is rewritten from address 0.
    run_tile(32'd0, 32'd0, 32'd0, 0, 1'b0, 500, 1'b0);
    run_tile(32'd0, 32'd0, 32'd0, 0, 1'b0, 0, 1'b0);
    check("restart_addr", wa[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
